// File: rtl/inst_pkg.sv
// Shared instruction-format definitions: opcode constants, format classes
// and the bit positions of each field inside a 32-bit instruction word.
package inst_pkg;

  localparam int WORD_W = 32;
  localparam int OPC_W  = 3;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 15;

  localparam int OPC_LSB = 29;
  localparam int RA0_LSB = 24;
  localparam int RA1_LSB = 19;
  localparam int RA2_LSB = 14;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_MEM_LO = 3'd4;
  localparam logic [OPC_W-1:0] OP_MEM_HI = 3'd5;
  localparam logic [OPC_W-1:0] OP_JUMP   = 3'd6;
  localparam logic [OPC_W-1:0] OP_HALT   = 3'd7;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_M,
    FMT_J,
    FMT_HALT
  } fmt_e;

  // Opcodes 0-3 are register-register, 4-5 memory, 6 jump, 7 halt.
  function automatic fmt_e fmt_of(input logic [OPC_W-1:0] op);
    fmt_e f;
    if (op < OP_MEM_LO)       f = FMT_R;
    else if (op <= OP_MEM_HI) f = FMT_M;
    else if (op == OP_JUMP)   f = FMT_J;
    else                      f = FMT_HALT;
    return f;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: places the fields used by the opcode's format into
// a 32-bit word, drops the unused ones and flags any that were nonzero.
module inst_pack
  import inst_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [REG_W-1:0]  reg_addr_0,
  input  logic [REG_W-1:0]  reg_addr_1,
  input  logic [REG_W-1:0]  reg_addr_2,
  input  logic [IMM_W-1:0]  addr,
  output logic [WORD_W-1:0] word,
  output logic              err
);

  // Build the word field by field; unused fields stay zero and raise err.
  always_comb begin
    word = '0;
    err  = 1'b0;
    word[OPC_LSB +: OPC_W] = opcode;
    case (fmt_of(opcode))
      FMT_R: begin
        word[RA0_LSB +: REG_W] = reg_addr_0;
        word[RA1_LSB +: REG_W] = reg_addr_1;
        word[RA2_LSB +: REG_W] = reg_addr_2;
        err = |addr;
      end
      FMT_M: begin
        word[RA0_LSB +: REG_W] = reg_addr_0;
        word[IMM_LSB +: IMM_W] = addr;
        err = |{reg_addr_1, reg_addr_2};
      end
      FMT_J: begin
        word[IMM_LSB +: IMM_W] = addr;
        err = |{reg_addr_0, reg_addr_1, reg_addr_2};
      end
      default: begin
        err = |{reg_addr_0, reg_addr_1, reg_addr_2, addr};
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts field tuples during a program load, packs
// them and writes one word per cycle into instruction memory, stopping on
// HALT or when the memory is full.
module inst_encoder
  import inst_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [REG_W-1:0]  reg_addr_0,
  input  logic [REG_W-1:0]  reg_addr_1,
  input  logic [REG_W-1:0]  reg_addr_2,
  input  logic [IMM_W-1:0]  addr,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [AW:0]       count,
  output logic              done,
  output logic              full,
  output logic              field_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] FULL = 2'd3;

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [1:0]        state;
  logic [AW-1:0]     ptr;
  logic [WORD_W-1:0] packed_word;
  logic              pack_err;
  logic              accept;

  inst_pack u_pack (
    .opcode     (opcode),
    .reg_addr_0 (reg_addr_0),
    .reg_addr_1 (reg_addr_1),
    .reg_addr_2 (reg_addr_2),
    .addr       (addr),
    .word       (packed_word),
    .err        (pack_err)
  );

  assign in_ready = (state == LOAD);
  assign accept   = in_valid && in_ready;

  // Load control: start opens a new load, each accepted tuple advances the
  // pointer until HALT or the last address ends the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      count     <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      field_err <= 1'b0;
    end else if (start && state != LOAD) begin
      state     <= LOAD;
      ptr       <= '0;
      count     <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      field_err <= 1'b0;
    end else if (accept) begin
      count <= count + (AW+1)'(1);
      if (pack_err) field_err <= 1'b1;
      if (opcode == OP_HALT) begin
        state <= DONE;
        done  <= 1'b1;
      end else if (ptr == LAST_PTR) begin
        state <= FULL;
        full  <= 1'b1;
      end else begin
        ptr <= ptr + AW'(1);
      end
    end
  end

  // Write register: the packed word lands on the memory port one cycle
  // after its tuple is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= ptr;
        mem_wdata <= packed_word;
      end
    end
  end

endmodule
